// File: rtl/serial_comparator_framed.sv
// serial_comparator_framed: framed bit-serial magnitude comparator with one-hot registered result
module serial_comparator_framed #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1,
  parameter bit SIGNED    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic sync,
  input  logic a,
  input  logic b,
  output logic res_valid,
  output logic a_less_b,
  output logic a_eq_b,
  output logic a_greater_b,
  output logic frame_error,
  output logic busy
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [CW-1:0] cnt_q, cnt_d, i;
  logic eq_q, lt_q, first, last, eq_in, lt_in, eq_d, lt_d;
  logic res_valid_q, lt_out_q, eq_out_q, gt_out_q, frame_error_q;
  // A frame start ignores whatever the accumulators hold and seeds eq=1, lt=0
  always_comb begin
    first = (cnt_q == '0) | sync;
    i     = first ? '0 : cnt_q;
    last  = i == LAST;
    eq_in = first | eq_q;
    lt_in = ~first & lt_q;
    eq_d  = eq_in & (a == b);
    lt_d  = MSB_FIRST ? ((SIGNED && i == '0) ? (a & ~b) : (lt_in | (eq_in & ~a & b)))
                      : ((a != b) ? ((SIGNED && last) ? (a & ~b) : (~a & b)) : lt_in);
    cnt_d = last ? '0 : i + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      eq_q          <= 1'b1;
      lt_q          <= 1'b0;
      res_valid_q   <= 1'b0;
      lt_out_q      <= 1'b0;
      eq_out_q      <= 1'b0;
      gt_out_q      <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      res_valid_q   <= in_valid & last;
      frame_error_q <= in_valid & sync & (cnt_q != '0);
      if (in_valid) begin
        cnt_q <= cnt_d;
        eq_q  <= eq_d;
        lt_q  <= lt_d;
      end
      if (in_valid & last) begin
        lt_out_q <= lt_d;
        eq_out_q <= eq_d;
        gt_out_q <= ~eq_d & ~lt_d;
      end
    end
  end
  assign res_valid   = res_valid_q;
  assign a_less_b    = lt_out_q;
  assign a_eq_b      = eq_out_q;
  assign a_greater_b = gt_out_q;
  assign frame_error = frame_error_q;
  assign busy        = cnt_q != '0;
endmodule

// File: tb/tb_serial_comparator_framed.sv
// tb_serial_comparator_framed: directed checks across five parameterisations sharing one stimulus stream
module tb_serial_comparator_framed;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic sync = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic rv [5];
  logic lt [5];
  logic eq [5];
  logic gt [5];
  logic fe [5];
  logic bz [5];
  int n_chk = 0;
  int n_err = 0;
  int fe_cnt;
  logic [7:0] va, vb;
  always #5 clk = ~clk;
  // 0: MSB unsigned, 1: MSB signed, 2: LSB unsigned, 3: LSB signed, 4: WIDTH=1
  for (genvar g = 0; g < 5; g++) begin : g_dut
    serial_comparator_framed #(
      .WIDTH(g == 4 ? 1 : 8),
      .MSB_FIRST((g < 2 || g == 4) ? 1'b1 : 1'b0),
      .SIGNED((g == 1 || g == 3) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .sync(sync), .a(a), .b(b),
      .res_valid(rv[g]), .a_less_b(lt[g]), .a_eq_b(eq[g]), .a_greater_b(gt[g]),
      .frame_error(fe[g]), .busy(bz[g])
    );
  end
  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic x, input logic y, input logic s);
    in_valid = 1'b1;
    a = x;
    b = y;
    sync = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sync = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic send_frame(input bit msb, input logic [7:0] x, input logic [7:0] y, input bit s0, input int k);
    int p;
    fe_cnt = 0;
    for (int j = 0; j < 8; j++) begin
      p = msb ? 7 - j : j;
      send_bit(x[p], y[p], s0 && j == 0);
      fe_cnt += int'(fe[0]);
      if (k >= 0 && j < 7) check($sformatf("rv_gap%0d_dut%0d", j, k), rv[k], 1'b0);
    end
  endtask
  initial begin
    idle(2);
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rst_rv%0d", g), rv[g], 1'b0);
      check($sformatf("rst_lt%0d", g), lt[g], 1'b0);
      check($sformatf("rst_eq%0d", g), eq[g], 1'b0);
      check($sformatf("rst_gt%0d", g), gt[g], 1'b0);
      check($sformatf("rst_fe%0d", g), fe[g], 1'b0);
      check($sformatf("rst_bz%0d", g), bz[g], 1'b0);
    end
    send_frame(1'b1, 8'h80, 8'h7F, 1'b0, 0);
    check("u_rv", rv[0], 1'b1);
    check("u_gt", gt[0], 1'b1);
    check("u_lt", lt[0], 1'b0);
    check("u_eq", eq[0], 1'b0);
    check("s_rv", rv[1], 1'b1);
    check("s_lt", lt[1], 1'b1);
    check("s_gt", gt[1], 1'b0);
    send_frame(1'b1, 8'hA5, 8'hA5, 1'b0, 1);
    check("s_eq_rv", rv[1], 1'b1);
    check("s_eq", eq[1], 1'b1);
    check("s_eq_lt", lt[1], 1'b0);
    idle(1);
    check("s_rv_pulse", rv[1], 1'b0);
    check("s_hold_eq", eq[1], 1'b1);
    do_reset();
    va = 8'h01;
    vb = 8'h02;
    for (int j = 0; j < 4; j++) send_bit(va[j], vb[j], 1'b0);
    check("lsb_busy_gap", bz[2], 1'b1);
    idle(3);
    check("lsb_busy_hold", bz[2], 1'b1);
    check("lsb_rv_gap", rv[2], 1'b0);
    for (int j = 4; j < 7; j++) send_bit(va[j], vb[j], 1'b0);
    check("lsb_rv_bit6", rv[2], 1'b0);
    send_bit(va[7], vb[7], 1'b0);
    check("lsb_rv", rv[2], 1'b1);
    check("lsb_lt", lt[2], 1'b1);
    check("lsb_gt", gt[2], 1'b0);
    check("lsb_busy_end", bz[2], 1'b0);
    do_reset();
    send_frame(1'b0, 8'hFF, 8'h01, 1'b0, 3);
    check("lsbs_rv", rv[3], 1'b1);
    check("lsbs_lt", lt[3], 1'b1);
    check("lsbs_gt", gt[3], 1'b0);
    check("lsbu_gt", gt[2], 1'b1);
    do_reset();
    va = 8'hFF;
    vb = 8'h00;
    for (int j = 0; j < 5; j++) send_bit(va[7-j], vb[7-j], 1'b0);
    check("sync_busy", bz[0], 1'b1);
    send_frame(1'b1, 8'h10, 8'h0F, 1'b1, 0);
    check("sync_fe_once", fe_cnt == 1, 1'b1);
    check("sync_rv", rv[0], 1'b1);
    check("sync_gt", gt[0], 1'b1);
    check("sync_lt", lt[0], 1'b0);
    check("sync_fe_clear", fe[0], 1'b0);
    for (int j = 0; j < 4; j++) send_bit(va[7-j], vb[7-j], 1'b0);
    do_reset();
    check("mrst_rv", rv[0], 1'b0);
    check("mrst_fe", fe[0], 1'b0);
    check("mrst_gt", gt[0], 1'b0);
    check("mrst_lt", lt[0], 1'b0);
    check("mrst_eq", eq[0], 1'b0);
    check("mrst_bz", bz[0], 1'b0);
    send_frame(1'b1, 8'h00, 8'h00, 1'b0, 0);
    check("mrst_fe_none", fe_cnt == 0, 1'b1);
    check("mrst_rv_end", rv[0], 1'b1);
    check("mrst_eq_end", eq[0], 1'b1);
    do_reset();
    send_bit(1'b0, 1'b1, 1'b0);
    check("w1_rv0", rv[4], 1'b1);
    check("w1_lt", lt[4], 1'b1);
    check("w1_bz0", bz[4], 1'b0);
    send_bit(1'b1, 1'b1, 1'b1);
    check("w1_rv1", rv[4], 1'b1);
    check("w1_eq", eq[4], 1'b1);
    check("w1_lt_clr", lt[4], 1'b0);
    check("w1_fe", fe[4], 1'b0);
    check("w1_bz1", bz[4], 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    check("w1_rv2", rv[4], 1'b1);
    check("w1_gt", gt[4], 1'b1);
    check("w1_eq_clr", eq[4], 1'b0);
    check("w1_bz2", bz[4], 1'b0);
    idle(1);
    check("w1_rv_idle", rv[4], 1'b0);
    check("w1_gt_hold", gt[4], 1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
